// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter / instruction register sequencing FSM
module pc_sequencer #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic [3:0] JMP_OP  = 4'hE,
  parameter logic [3:0] BR_OP   = 4'hD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [15:0] ir_in,
  input  logic        ex_done,
  input  logic        br_cond,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        ex_start,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] fetch_count
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_BRANCH = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [3:0] opcode_q;
  logic       take_q;
  logic       ex_first_q;
  logic       fetch_fire;

  assign state      = state_q;
  assign fetch_fire = (state_q == ST_FETCH) && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode_q == HALT_OP) begin
          state_d = ST_HALT;
        end else if ((opcode_q == JMP_OP) || (opcode_q == BR_OP)) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = ex_done ? ST_FETCH : ST_EXEC;
      ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:   state_d = run ? ST_FETCH : ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  // Opcode, branch-take flag, EXEC entry flag and debug fetch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q    <= 4'h0;
      take_q      <= 1'b0;
      ex_first_q  <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      if (fetch_fire) begin
        opcode_q    <= ir_in[15:12];
        fetch_count <= fetch_count + 16'h0001;
      end
      if (state_q == ST_DECODE) begin
        if (opcode_q == JMP_OP) begin
          take_q <= 1'b1;
        end else if (opcode_q == BR_OP) begin
          take_q <= br_cond;
        end
      end else if (state_q == ST_BRANCH) begin
        take_q <= 1'b0;
      end
      ex_first_q <= (state_q == ST_DECODE) && (state_d == ST_EXEC);
    end
  end

  // pc_ld is gated to BRANCH and pc_inc to FETCH, so they can never overlap.
  always_comb begin
    mem_rd   = (state_q == ST_FETCH);
    ir_ld    = fetch_fire;
    pc_inc   = fetch_fire;
    pc_ld    = (state_q == ST_BRANCH) && take_q;
    ex_start = (state_q == ST_EXEC) && ex_first_q;
    halted   = (state_q == ST_HALT);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        mem_ready;
  logic [15:0] ir_in;
  logic        ex_done;
  logic        br_cond;
  logic        pc_ld;
  logic        pc_inc;
  logic        ir_ld;
  logic        mem_rd;
  logic        ex_start;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] fetch_count;

  int tests = 0;
  int fails = 0;
  int excl_viol = 0;
  logic [15:0] exp_fc = 16'h0000;
  logic [27:0] exp_q[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir_in(ir_in),
    .ex_done(ex_done), .br_cond(br_cond), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .ir_ld(ir_ld), .mem_rd(mem_rd), .ex_start(ex_start), .halted(halted),
    .state(state), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pc_ld && pc_inc) excl_viol++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] observed();
    return {4'h0, state, mem_rd, ir_ld, pc_inc, pc_ld, ex_start, halted, fetch_count};
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected outputs of the coming cycle, then compare at negedge.
  task automatic step(input string tag, input logic [2:0] st, input logic rd,
                      input logic fetch, input logic ld, input logic exs, input logic h);
    exp_q.push_back({4'h0, st, rd, fetch, fetch, ld, exs, h, exp_fc});
    if (fetch) exp_fc = exp_fc + 16'h0001;
    @(negedge clk);
    check(tag, observed(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b1; ir_in = 16'h1234;
    ex_done = 1'b1; br_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 3'd0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // ALU instruction with memory and execution unit always ready
    step("t1_init",   3'd0, 0, 0, 0, 0, 0);
    step("t1_fetch",  3'd1, 1, 1, 0, 0, 0);
    step("t1_decode", 3'd2, 0, 0, 0, 0, 0);
    step("t1_exec",   3'd3, 0, 0, 0, 1, 0);

    // Memory wait states, then a taken conditional branch
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("t2_wait", 3'd1, 1, 0, 0, 0, 0);
    mem_ready = 1'b1; ir_in = 16'hD000; br_cond = 1'b1;
    step("t2_fetch",  3'd1, 1, 1, 0, 0, 0);
    step("t3_dec_bt", 3'd2, 0, 0, 0, 0, 0);
    br_cond = 1'b0;
    step("t3_br_tk",  3'd4, 0, 0, 1, 0, 0);
    step("t3_fetch",  3'd1, 1, 1, 0, 0, 0);
    step("t3_dec_bn", 3'd2, 0, 0, 0, 0, 0);
    ir_in = 16'hE000;
    step("t3_br_nt",  3'd4, 0, 0, 0, 0, 0);
    step("t3_fetchj", 3'd1, 1, 1, 0, 0, 0);
    step("t3_dec_j",  3'd2, 0, 0, 0, 0, 0);
    ir_in = 16'hF000;
    step("t3_jmp",    3'd4, 0, 0, 1, 0, 0);

    // Halt, hold, and restart with a single run pulse
    step("t4_fetch",  3'd1, 1, 1, 0, 0, 0);
    step("t4_decode", 3'd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("t4_hold", 3'd5, 0, 0, 0, 0, 1);
    run = 1'b1;
    step("t4_run",    3'd5, 0, 0, 0, 0, 1);
    run = 1'b0; ir_in = 16'h1234; ex_done = 1'b0;
    step("t4_resume", 3'd1, 1, 1, 0, 0, 0);

    // EXEC waiting on ex_done
    step("t5_decode", 3'd2, 0, 0, 0, 0, 0);
    step("t5_exec0",  3'd3, 0, 0, 0, 1, 0);
    step("t5_exec1",  3'd3, 0, 0, 0, 0, 0);
    step("t5_exec2",  3'd3, 0, 0, 0, 0, 0);
    ex_done = 1'b1;
    step("t5_exec3",  3'd3, 0, 0, 0, 0, 0);
    ex_done = 1'b0;
    step("t5_fetch",  3'd1, 1, 1, 0, 0, 0);
    step("t5_dec2",   3'd2, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of EXEC
    @(negedge clk);
    check("t5_pre_rst", observed(), {4'h0, 3'd3, 6'b000010, exp_fc});
    #1;
    reset = 1'b1;
    #1;
    check("t5_async_rst", observed(), 28'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_fc = 16'h0000;
    ex_done = 1'b1;

    // fetch_count wrap after 65536 fetches
    step("t6_init", 3'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) begin
      repeat (3) @(posedge clk);
      exp_fc = exp_fc + 16'h0001;
    end
    #1;
    step("t6_fetch_fffe", 3'd1, 1, 1, 0, 0, 0);
    step("t6_dec_ffff",   3'd2, 0, 0, 0, 0, 0);
    step("t6_exec",       3'd3, 0, 0, 0, 1, 0);
    step("t6_fetch_ffff", 3'd1, 1, 1, 0, 0, 0);
    step("t6_dec_wrap",   3'd2, 0, 0, 0, 0, 0);

    check("ld_inc_excl", 28'(excl_viol), 28'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
